// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the HI/LO multiply/divide controller.
// Holds op codes, FSM state codes, ALU control words and the default width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_MULT  = 4'b0000,
        OP_MULTU = 4'b0001,
        OP_MADD  = 4'b0010,
        OP_MSUB  = 4'b0011,
        OP_DIV   = 4'b0100,
        OP_DIVU  = 4'b0101,
        OP_MTHI  = 4'b0110,
        OP_MTLO  = 4'b0111
    } mdu_op_e;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_ACC  = 3'd2;
    localparam logic [2:0] ST_DIV  = 3'd3;
    localparam logic [2:0] ST_FIX  = 3'd4;

    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SMUL = 5'b01000;
    localparam logic [4:0] ALU_UMUL = 5'b10001;

    // MULT, MULTU, MADD and MSUB all live in the 00xx corner of the op space.
    function automatic logic is_mul(input logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division iteration.
// Shifts the next dividend bit into the remainder and subtracts the divisor if it fits.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvs_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;

    assign sh    = {rem_i, bit_i};
    assign diff  = sh - {1'b0, dvs_i};
    assign q_o   = ~diff[WIDTH];
    assign rem_o = q_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: HI/LO owner that sequences multiply/accumulate through the shared ALU.
// Iterative DIV/DIVU and the divide datapath are compiled only when MDU_DIV_EN is defined.
module hilo_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [3:0]           Op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [4:0]           AluCtl,
    output logic [WIDTH-1:0]     AluA,
    output logic [WIDTH-1:0]     AluB,
    input  logic [2*WIDTH-1:0]   AluResult,
    output logic                 Busy,
    output logic                 Done,
    output logic                 DivByZero,
    output logic [WIDTH-1:0]     Hi,
    output logic [WIDTH-1:0]     Lo
);

    logic [2:0]           state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0]   p_q, p_d, hilo;

    assign hilo = {hi_q, lo_q};
    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = state_q != ST_IDLE;

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0] rem_q, rem_d, dq_q, dq_d, dvs, rem_nx, quo_s, rem_s;
    logic [5:0]       cnt_q, cnt_d;
    logic             q_bit, a_neg, b_neg;

    // Division runs on magnitudes; dq_q starts as the dividend and fills with quotient bits.
    assign a_neg     = (op_q == OP_DIV) & a_q[WIDTH-1];
    assign b_neg     = (op_q == OP_DIV) & b_q[WIDTH-1];
    assign dvs       = b_neg ? -b_q : b_q;
    assign quo_s     = (a_neg ^ b_neg) ? -dq_q : dq_q;
    assign rem_s     = a_neg ? -rem_q : rem_q;
    assign DivByZero = (state_q == ST_FIX) && (b_q == '0);

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dvs_i (dvs),
        .bit_i (dq_q[WIDTH-1]),
        .rem_o (rem_nx),
        .q_o   (q_bit)
    );
`else
    assign DivByZero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        AluCtl  = ALU_ADD;
        AluA    = '0;
        AluB    = '0;
        Done    = 1'b0;
`ifdef MDU_DIV_EN
        rem_d   = rem_q;
        dq_d    = dq_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Op == OP_MTHI) hi_d = A;
                    else if (Op == OP_MTLO) lo_d = A;
                    else if (is_mul(Op)) begin
                        op_d    = Op;
                        a_d     = A;
                        b_d     = B;
                        state_d = ST_MUL;
                    end
`ifdef MDU_DIV_EN
                    else if (Op == OP_DIV || Op == OP_DIVU) begin
                        op_d    = Op;
                        a_d     = A;
                        b_d     = B;
                        rem_d   = '0;
                        cnt_d   = 6'd31;
                        dq_d    = (Op == OP_DIV && A[WIDTH-1]) ? -A : A;
                        state_d = (B == '0) ? ST_FIX : ST_DIV;
                    end
`endif
                end
            end
            ST_MUL: begin
                AluCtl = (op_q == OP_MULTU) ? ALU_UMUL : ALU_SMUL;
                AluA   = a_q;
                AluB   = b_q;
                p_d    = AluResult;
                if (op_q[1]) state_d = ST_ACC;
                else begin
                    {hi_d, lo_d} = AluResult;
                    Done         = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_ACC: begin
                {hi_d, lo_d} = op_q[0] ? hilo - p_q : hilo + p_q;
                Done         = 1'b1;
                state_d      = ST_IDLE;
            end
`ifdef MDU_DIV_EN
            ST_DIV: begin
                rem_d   = rem_nx;
                dq_d    = {dq_q[WIDTH-2:0], q_bit};
                cnt_d   = cnt_q - 6'd1;
                state_d = (cnt_q == 6'd0) ? ST_FIX : ST_DIV;
            end
            ST_FIX: begin
                {hi_d, lo_d} = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem_s, quo_s};
                Done         = 1'b1;
                state_d      = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MDU_DIV_EN
            rem_q   <= '0;
            dq_q    <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MDU_DIV_EN
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl: directed bench for hilo_mdu_ctrl with a behavioural shared-ALU model.
// Divide checks follow MDU_DIV_EN; without it the divide ops must be ignored.
module tb_hilo_mdu_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  Op = 4'h0;
    logic [31:0] A = '0, B = '0;
    logic [4:0]  AluCtl;
    logic [31:0] AluA, AluB, Hi, Lo;
    logic [63:0] AluResult, sa, sb;
    logic        Busy, Done, DivByZero;
    int          checks = 0, errors = 0;

    always #5 Clk = ~Clk;

    assign sa = {{32{AluA[31]}}, AluA};
    assign sb = {{32{AluB[31]}}, AluB};
    assign AluResult = (AluCtl == 5'b01000) ? sa * sb :
                       (AluCtl == 5'b10001) ? {32'b0, AluA} * {32'b0, AluB} :
                       {32'b0, AluA + AluB};

    hilo_mdu_ctrl #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .AluCtl(AluCtl), .AluA(AluA), .AluB(AluB), .AluResult(AluResult),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    task automatic cyc;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        cyc();
        Start = 1'b0;
        Op    = 4'hF;
        A     = 32'hDEAD_BEEF;
        B     = 32'h1234_5678;
    endtask

    initial begin
        #2 Rst = 1'b0;
        cyc();
        cyc();
        chk("rst_hi", Hi, 0);
        chk("rst_lo", Lo, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_dvz", DivByZero, 0);
        Rst = 1'b1;
        cyc();
        chk("idle_aluctl", AluCtl, 5'b00010);
        chk("idle_alua", AluA, 0);

        issue(4'b0000, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy", Busy, 1);
        chk("mult_done", Done, 1);
        chk("mult_aluctl", AluCtl, 5'b01000);
        chk("mult_alua", AluA, 32'hFFFF_FFFE);
        cyc();
        chk("mult_busy_off", Busy, 0);
        chk("mult_done_off", Done, 0);
        chk("mult_hi", Hi, 32'hFFFF_FFFF);
        chk("mult_lo", Lo, 32'hFFFF_FFFA);

        issue(4'b0001, 32'hFFFF_FFFF, 32'd2);
        chk("multu_aluctl", AluCtl, 5'b10001);
        chk("multu_done", Done, 1);
        cyc();
        chk("multu_hi", Hi, 32'h0000_0001);
        chk("multu_lo", Lo, 32'hFFFF_FFFE);

        issue(4'b0110, 32'h0, 32'h0);
        chk("mthi_busy", Busy, 0);
        chk("mthi_done", Done, 0);
        chk("mthi_hi", Hi, 0);
        issue(4'b0111, 32'hFFFF_FFFF, 32'h0);
        chk("mtlo_lo", Lo, 32'hFFFF_FFFF);
        chk("mtlo_hi", Hi, 0);

        issue(4'b0010, 32'd1, 32'd1);
        chk("madd_t1_busy", Busy, 1);
        chk("madd_t1_done", Done, 0);
        cyc();
        chk("madd_t2_busy", Busy, 1);
        chk("madd_t2_done", Done, 1);
        cyc();
        chk("madd_busy_off", Busy, 0);
        chk("madd_hi", Hi, 32'd1);
        chk("madd_lo", Lo, 32'd0);

        issue(4'b0011, 32'd2, 32'd3);
        cyc();
        chk("msub_done", Done, 1);
        cyc();
        chk("msub_hi", Hi, 32'd0);
        chk("msub_lo", Lo, 32'hFFFF_FFFA);

        issue(4'b1000, 32'd7, 32'd7);
        chk("illegal_busy", Busy, 0);
        chk("illegal_lo", Lo, 32'hFFFF_FFFA);

`ifdef MDU_DIV_EN
        begin
            int early = 0;
            issue(4'b0100, 32'hFFFF_FFF9, 32'd2);
            chk("div_t1_busy", Busy, 1);
            for (int i = 0; i < 31; i++) begin
                if (Done) early++;
                cyc();
            end
            chk("div_no_early_done", early, 0);
            chk("div_t32_done", Done, 0);
            cyc();
            chk("div_t33_done", Done, 1);
            chk("div_t33_dvz", DivByZero, 0);
            cyc();
            chk("div_busy_off", Busy, 0);
            chk("div_lo", Lo, 32'hFFFF_FFFD);
            chk("div_hi", Hi, 32'hFFFF_FFFF);
        end

        issue(4'b0101, 32'd100, 32'd0);
        chk("dvz_busy", Busy, 1);
        chk("dvz_done", Done, 1);
        chk("dvz_flag", DivByZero, 1);
        cyc();
        chk("dvz_lo", Lo, 32'hFFFF_FFFF);
        chk("dvz_hi", Hi, 32'd100);

        issue(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (33) cyc();
        chk("ovf_lo", Lo, 32'h8000_0000);
        chk("ovf_hi", Hi, 32'h0);

        issue(4'b0101, 32'd100, 32'd7);
        repeat (33) cyc();
        chk("divu_lo", Lo, 32'd14);
        chk("divu_hi", Hi, 32'd2);

        issue(4'b0100, 32'd50, 32'd3);
        repeat (9) cyc();
        chk("abort_pre_busy", Busy, 1);
        Rst = 1'b0;
        #1;
        chk("abort_hi", Hi, 0);
        chk("abort_lo", Lo, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
`else
        issue(4'b0100, 32'hFFFF_FFF9, 32'd2);
        chk("nodiv_busy", Busy, 0);
        chk("nodiv_lo", Lo, 32'hFFFF_FFFA);
        issue(4'b0101, 32'd100, 32'd0);
        chk("nodivu_busy", Busy, 0);
        chk("nodivu_dvz", DivByZero, 0);

        issue(4'b0010, 32'd4, 32'd4);
        chk("abort_pre_busy", Busy, 1);
        Rst = 1'b0;
        #1;
        chk("abort_hi", Hi, 0);
        chk("abort_lo", Lo, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
`endif
        cyc();
        Rst = 1'b1;
        cyc();
        chk("post_abort_lo", Lo, 0);

        Start = 1'b1;
        Op    = 4'b0010;
        A     = 32'd2;
        B     = 32'd3;
        cyc();
        Op = 4'b0000;
        A  = 32'd5;
        B  = 32'd5;
        chk("retry_t1_busy", Busy, 1);
        chk("retry_t1_done", Done, 0);
        cyc();
        chk("retry_t2_done", Done, 1);
        chk("retry_t2_busy", Busy, 1);
        cyc();
        chk("retry_t3_busy", Busy, 0);
        chk("retry_madd_lo", Lo, 32'd6);
        chk("retry_madd_hi", Hi, 32'd0);
        cyc();
        Start = 1'b0;
        chk("retry_mult_busy", Busy, 1);
        chk("retry_mult_done", Done, 1);
        chk("retry_mult_aluctl", AluCtl, 5'b01000);
        cyc();
        chk("retry_mult_lo", Lo, 32'd25);
        chk("retry_mult_hi", Hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_mdu_ctrl.md
# hilo_mdu_ctrl

- Multiply/divide controller for the MIPS datapath.
- Owns the architectural HI/LO registers.
- Sequences MULT/MULTU/MADD/MSUB through the shared 32-bit ALU (64-bit product path), performs DIV/DIVU iteratively, and handles MTHI/MTLO.
- Sits beside the EX stage; `Busy` stalls the pipeline while an operation is in flight.

## Interface
- `WIDTH`, default 32 — operand width; the HI/LO pair is 2*WIDTH.
- `Clk` in 1 — clock, rising edge.
- `Rst` in 1 — reset, asynchronous, active-low.
- `Start` in 1 — issue strobe; accepted only when `Busy`=0.
- `Op` in 4 — 0000 MULT, 0001 MULTU, 0010 MADD, 0011 MSUB, 0100 DIV, 0101 DIVU, 0110 MTHI, 0111 MTLO; 1xxx illegal.
- `A`, `B` in WIDTH — rs/rt operands, sampled on the accepting edge.
- `AluCtl` out 5 — control to the shared ALU.
- `AluA`, `AluB` out WIDTH — operands to the shared ALU.
- `AluResult` in 2*WIDTH — product returned by the ALU.
- `Busy` out 1 — operation in flight.
- `Done` out 1 — one-cycle pulse in the cycle whose closing edge writes HI/LO.
- `DivByZero` out 1 — pulses with `Done` when the divisor was 0.
- `Hi`, `Lo` out WIDTH — architectural HI/LO.

## Operation
**States:** IDLE, MUL, ACC, DIV, FIX.

**Reset:**
- Outputs: `Hi`=`Lo`=0, `Busy`=0, `Done`=0, `DivByZero`=0.
- State goes to IDLE.
- Operand latches and the iteration counter clear.

**IDLE:**
- Drives `AluCtl`=5'b00010 (ADD) with `AluA`=`AluB`=0.
- `Start` with MTHI/MTLO writes `A` into HI/LO at that edge, stays in IDLE, no `Busy`, no `Done`.
- `Start` with an illegal op is ignored.

**MUL:**
- Drives `AluCtl`=5'b01000 (signed) or 5'b10001 (unsigned) from the latched A/B.
- Captures `AluResult` into a 64-bit product register P.
- MULT/MULTU: write {HI,LO}=P and return to IDLE.
- MADD/MSUB: go to ACC.

**ACC:**
- {HI,LO} = {HI,LO} ± P using the controller's own 64-bit adder; the result wraps modulo 2^64.
- Returns to IDLE.

**DIV:**
- Restoring division on operand magnitudes, one quotient bit per cycle.
- A 6-bit counter runs 31 down to 0; after the last bit, go to FIX.
- B=0 on acceptance: skip DIV and go directly to FIX.

**FIX:**
- Applies signs (DIVS only): quotient is negative when the operand signs differ; the remainder takes the dividend's sign.
- Writes LO=quotient, HI=remainder.
- Divide by zero: LO=0xFFFFFFFF, HI=A, `DivByZero`=1.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0.

**Busy/Done:**
- `Busy` = state≠IDLE.
- `Done` asserts in the final state of MUL (MULT/MULTU), ACC, and FIX.

## Timing
Start accepted at the edge closing cycle T.

**Latency:**
- MULT/MULTU: `Busy` and `Done` in T+1; new HI/LO visible from T+2.
- MADD/MSUB: `Busy` T+1..T+2, `Done` T+2; HI/LO visible from T+3.
- DIV/DIVU: `Busy` T+1..T+33, `Done` T+33; HI/LO visible from T+34.
- Divide by zero: `Busy` and `Done` in T+1.
- MTHI/MTLO: value visible from T+1.

**Boundary conditions:**
- `Start` while `Busy` is ignored; it is not queued.
- `Start` in the `Done` cycle is ignored because `Busy` is still 1; it is accepted the following cycle.
- `A`/`B`/`Op` are don't-care after acceptance.
- `Rst` asserted mid-operation aborts immediately: HI/LO=0 and no `Done`.

## Configuration
**With `MDU_DIV_EN` defined:**
- DIV/DIVU behave as described.

**Without `MDU_DIV_EN`:**
- Ops 0100/0101 are treated as illegal and ignored.
- The DIV and FIX states, the divide datapath and the counter are not compiled.
- `DivByZero` is tied to 0.

## Structure
**Package `mdu_pkg`:**
- Op encodings.
- State enum.
- ALU control constants: ADD 5'b00010, signed multiply 5'b01000, unsigned multiply 5'b10001.
- `WIDTH` default.

**Sub-module `mdu_div_step`:**
- Combinational single restoring iteration.
- Inputs: partial remainder, divisor, next dividend bit.
- Outputs: new remainder and quotient bit.
- Instantiated only under `MDU_DIV_EN`.

## Test plan
- MULT A=0xFFFFFFFE (-2), B=3 → Done at T+1; Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; AluCtl=01000 in T+1.
- MULTU A=0xFFFFFFFF, B=2 → Hi=0x00000001, Lo=0xFFFFFFFE; AluCtl=10001.
- MTHI 0, MTLO 0xFFFFFFFF, then MADD A=1, B=1 → Hi=1, Lo=0 (carry across LO), Done at T+2.
- DIV A=-7, B=2 → Done at T+33; Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- DIVU A=100, B=0 → Done and DivByZero at T+1; Lo=0xFFFFFFFF, Hi=100.
- Start DIV, assert Rst at T+10 → Hi=Lo=0, Busy=0, no Done. Then issue a MULT during Busy and in the Done cycle → MULT is ignored both times and accepted on retry.
